// File: rtl/ahb_master_arb_pkg.sv
// ahb_master_arb_pkg: HBURST encodings, burst beat count and arbiter FSM states
package ahb_master_arb_pkg;
   localparam logic [2:0] HB_SINGLE = 3'd0;
   localparam logic [2:0] HB_INCR   = 3'd1;
   localparam logic [2:0] HB_WRAP4  = 3'd2;
   localparam logic [2:0] HB_INCR4  = 3'd3;
   localparam logic [2:0] HB_WRAP8  = 3'd4;
   localparam logic [2:0] HB_INCR8  = 3'd5;
   localparam logic [2:0] HB_WRAP16 = 3'd6;
   localparam logic [2:0] HB_INCR16 = 3'd7;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_LOCKED} state_t;
   function automatic logic [4:0] burst_beats(input logic [2:0] b);
      case (b)
         HB_WRAP4, HB_INCR4:   return 5'd4;
         HB_WRAP8, HB_INCR8:   return 5'd8;
         HB_WRAP16, HB_INCR16: return 5'd16;
         default:              return 5'd1;
      endcase
   endfunction
endpackage

// File: rtl/ahb_master_arb_if.sv
// ahb_master_arb_if: channel-side and master-port signals; strobes only with AHB_ARB_WSTRB_EN
interface ahb_master_arb_if #(
   parameter int CH_NUM     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [CH_NUM-1:0]            ch_valid;
   logic [CH_NUM*ADDR_WIDTH-1:0] ch_addr;
   logic [CH_NUM*3-1:0]          ch_burst;
   logic [CH_NUM*4-1:0]          ch_size;
   logic [CH_NUM-1:0]            ch_write;
   logic [CH_NUM*DATA_WIDTH-1:0] ch_wdata;
   logic [CH_NUM-1:0]            ch_ready;
   logic [CH_NUM-1:0]            ch_error;
   logic [DATA_WIDTH-1:0]        ch_rdata;
   logic                         m_valid;
   logic [ADDR_WIDTH-1:0]        m_addr;
   logic [2:0]                   m_burst;
   logic [3:0]                   m_size;
   logic                         m_write;
   logic [DATA_WIDTH-1:0]        m_wdata;
   logic                         m_ready;
   logic [DATA_WIDTH-1:0]        m_rdata;
   logic                         m_master_error;
   logic                         m_other_error;
`ifdef AHB_ARB_WSTRB_EN
   logic [CH_NUM*DATA_WIDTH/8-1:0] ch_strb;
   logic [DATA_WIDTH/8-1:0]        m_strb;
`endif
   modport master (
`ifdef AHB_ARB_WSTRB_EN
      input ch_strb, output m_strb,
`endif
      input ch_valid, ch_addr, ch_burst, ch_size, ch_write, ch_wdata,
      input m_ready, m_rdata, m_master_error, m_other_error,
      output ch_ready, ch_error, ch_rdata,
      output m_valid, m_addr, m_burst, m_size, m_write, m_wdata
   );
   modport slave (
`ifdef AHB_ARB_WSTRB_EN
      output ch_strb, input m_strb,
`endif
      output ch_valid, ch_addr, ch_burst, ch_size, ch_write, ch_wdata,
      output m_ready, m_rdata, m_master_error, m_other_error,
      input ch_ready, ch_error, ch_rdata,
      input m_valid, m_addr, m_burst, m_size, m_write, m_wdata
   );
endinterface

// File: rtl/ahb_master_arb_rr_arb.sv
// ahb_master_arb_rr_arb: round-robin pick of the first requester after the pointer
module ahb_master_arb_rr_arb #(
   parameter int CH_NUM = 4,
   parameter int IW     = $clog2(CH_NUM)
) (
   input  logic [CH_NUM-1:0] i_req,
   input  logic [IW-1:0]     i_ptr,
   output logic [CH_NUM-1:0] o_grant,
   output logic [IW-1:0]     o_idx
);
   localparam logic [CH_NUM-1:0] ONE = CH_NUM'(1);
   logic [IW-1:0] w_c;
   // scan from farthest to nearest so the nearest requester after the pointer is kept
   always_comb begin
      o_idx = '0;
      w_c   = '0;
      for (int k = CH_NUM; k >= 1; k--) begin
         w_c = IW'((int'(i_ptr) + k) % CH_NUM);
         if (i_req[w_c]) o_idx = w_c;
      end
      o_grant = |i_req ? ONE << o_idx : '0;
   end
endmodule

// File: rtl/ahb_master_arb.sv
// ahb_master_arb: N-channel round-robin front end with burst lock into one AHB master port; AHB_ARB_WSTRB_EN adds write strobes
module ahb_master_arb #(
   parameter int CH_NUM     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input logic             clk,
   input logic             rstn,
   ahb_master_arb_if.master bus
);
   import ahb_master_arb_pkg::*;
   localparam int IW = $clog2(CH_NUM);
   localparam logic [CH_NUM-1:0] ONE = CH_NUM'(1);
   state_t                r_state, w_next;
   logic [IW-1:0]         r_owner, r_ptr, w_win, w_sel;
   logic [CH_NUM-1:0]     w_gnt;
   logic [3:0]            r_cnt;
   logic                  w_load, w_done, w_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_burst;
   logic [3:0]            r_size;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_wdata;
`ifdef AHB_ARB_WSTRB_EN
   localparam int SW = DATA_WIDTH / 8;
   logic [SW-1:0]         r_strb;
`endif
   ahb_master_arb_rr_arb #(.CH_NUM(CH_NUM)) u_rr (
      .i_req   (bus.ch_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_gnt),
      .o_idx   (w_win)
   );
   assign w_sel  = r_state == ST_LOCKED ? r_owner : w_win;
   assign w_load = r_state == ST_IDLE ? |w_gnt : r_state == ST_LOCKED && bus.ch_valid[r_owner];
   assign w_done = r_state == ST_ISSUE && bus.m_ready;
   assign w_err  = bus.m_master_error | bus.m_other_error;
   // state register
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   // next state: load a beat, or on completion end/abort the burst or wait for the owner's next beat
   always_comb begin
      w_next = r_state;
      if (w_load)      w_next = ST_ISSUE;
      else if (w_done) w_next = (r_cnt == 4'd0 || w_err) ? ST_IDLE : ST_LOCKED;
   end
   // beat registers, owner, round-robin pointer and remaining-beat counter
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_addr  <= '0;
         r_burst <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
         r_wdata <= '0;
         r_owner <= '0;
         r_ptr   <= IW'(CH_NUM - 1);
         r_cnt   <= '0;
`ifdef AHB_ARB_WSTRB_EN
         r_strb  <= '0;
`endif
      end else if (w_load) begin
         r_addr  <= bus.ch_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
         r_burst <= bus.ch_burst[w_sel*3 +: 3];
         r_size  <= bus.ch_size[w_sel*4 +: 4];
         r_write <= bus.ch_write[w_sel];
         r_wdata <= bus.ch_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
         r_owner <= w_sel;
         r_ptr   <= w_sel;
`ifdef AHB_ARB_WSTRB_EN
         r_strb  <= bus.ch_strb[w_sel*SW +: SW];
`endif
         if (r_state == ST_IDLE) r_cnt <= 4'(burst_beats(bus.ch_burst[w_sel*3 +: 3]) - 5'd1);
      end else if (w_done && !w_err && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   assign bus.m_valid  = r_state == ST_ISSUE;
   assign bus.m_addr   = r_addr;
   assign bus.m_burst  = r_burst;
   assign bus.m_size   = r_size;
   assign bus.m_write  = r_write;
   assign bus.m_wdata  = r_wdata;
`ifdef AHB_ARB_WSTRB_EN
   assign bus.m_strb   = r_strb;
`endif
   assign bus.ch_ready = w_done ? ONE << r_owner : '0;
   assign bus.ch_error = w_done && w_err ? ONE << r_owner : '0;
   assign bus.ch_rdata = w_done ? bus.m_rdata : '0;
endmodule

// File: tb/tb_ahb_master_arb.sv
// tb_ahb_master_arb: directed vector table plus burst/error/stall/reset sequences for ahb_master_arb
module tb_ahb_master_arb;
   import ahb_master_arb_pkg::*;
   localparam int CH = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   ahb_master_arb_if #(.CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   ahb_master_arb #(.CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );
   typedef struct {
      logic [3:0]  cv;
      logic        mr;
      logic        er;
      logic        mv;
      logic [31:0] addr;
      logic [3:0]  cr;
      logic [3:0]  ce;
   } vec_t;
   vec_t vt[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_ch(input int i, input logic [31:0] a, input logic [2:0] b, input logic w, input logic [31:0] d);
      bus.ch_addr[i*AW +: AW]  = a;
      bus.ch_burst[i*3 +: 3]   = b;
      bus.ch_size[i*4 +: 4]    = 4'd2;
      bus.ch_write[i]          = w;
      bus.ch_wdata[i*DW +: DW] = d;
   endtask

   // called in the low clock phase; waits for a loaded beat, completes it, checks the bubble after
   task automatic beat(input string nm, input logic [31:0] ea, input logic [3:0] ecr, input logic oe);
      int n = 0;
      while (bus.m_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({nm, " load"}, 32'(n < 20), 32'd1);
      bus.m_ready = 1'b1;
      bus.m_other_error = oe;
      bus.m_rdata = ea ^ 32'hFFFF_0000;
      #1;
      chk({nm, " addr"}, bus.m_addr, ea);
      chk({nm, " ch_ready"}, 32'(bus.ch_ready), 32'(ecr));
      chk({nm, " ch_error"}, 32'(bus.ch_error), oe ? 32'(ecr) : 32'd0);
      chk({nm, " ch_rdata"}, bus.ch_rdata, ea ^ 32'hFFFF_0000);
      @(negedge clk);
      bus.m_ready = 1'b0;
      bus.m_other_error = 1'b0;
      #1;
      chk({nm, " bubble"}, 32'(bus.m_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 32'h0000, 4'b0000, 4'b0000};
      vt[1]  = '{4'b1111, 1'b1, 1'b0, 1'b1, 32'h0040, 4'b0001, 4'b0000};
      vt[2]  = '{4'b1110, 1'b0, 1'b0, 1'b0, 32'h0040, 4'b0000, 4'b0000};
      vt[3]  = '{4'b1110, 1'b1, 1'b0, 1'b1, 32'h1040, 4'b0010, 4'b0000};
      vt[4]  = '{4'b1100, 1'b0, 1'b0, 1'b0, 32'h1040, 4'b0000, 4'b0000};
      vt[5]  = '{4'b1100, 1'b1, 1'b0, 1'b1, 32'h2040, 4'b0100, 4'b0000};
      vt[6]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 32'h2040, 4'b0000, 4'b0000};
      vt[7]  = '{4'b1000, 1'b1, 1'b0, 1'b1, 32'h3040, 4'b1000, 4'b0000};
      vt[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 32'h3040, 4'b0000, 4'b0000};
      vt[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 32'h3040, 4'b0000, 4'b0000};
      vt[10] = '{4'b0110, 1'b0, 1'b0, 1'b0, 32'h3040, 4'b0000, 4'b0000};
      vt[11] = '{4'b0110, 1'b1, 1'b0, 1'b1, 32'h1040, 4'b0010, 4'b0000};
      vt[12] = '{4'b0100, 1'b0, 1'b0, 1'b0, 32'h1040, 4'b0000, 4'b0000};
      vt[13] = '{4'b0100, 1'b1, 1'b0, 1'b1, 32'h2040, 4'b0100, 4'b0000};
      vt[14] = '{4'b0001, 1'b0, 1'b0, 1'b0, 32'h2040, 4'b0000, 4'b0000};
      vt[15] = '{4'b0001, 1'b1, 1'b1, 1'b1, 32'h0040, 4'b0001, 4'b0001};
      vt[16] = '{4'b0000, 1'b0, 1'b0, 1'b0, 32'h0040, 4'b0000, 4'b0000};
      bus.ch_valid = '0;
      bus.ch_addr = '0;
      bus.ch_burst = '0;
      bus.ch_size = '0;
      bus.ch_write = '0;
      bus.ch_wdata = '0;
      bus.m_ready = 1'b0;
      bus.m_rdata = '0;
      bus.m_master_error = 1'b0;
      bus.m_other_error = 1'b0;
`ifdef AHB_ARB_WSTRB_EN
      bus.ch_strb = '0;
`endif
      for (int i = 0; i < CH; i++) set_ch(i, 32'h1000 * i + 32'h40, HB_SINGLE, 1'b1, 32'hA0 + i);
      repeat (2) @(negedge clk);
      #1;
      chk("reset m_valid", 32'(bus.m_valid), 32'd0);
      chk("reset m_addr", bus.m_addr, 32'd0);
      chk("reset m_wdata", bus.m_wdata, 32'd0);
      chk("reset ch_ready", 32'(bus.ch_ready), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      // single-beat round robin, ignored m_ready, error on a single beat
      for (int i = 0; i < 17; i++) begin
         bus.ch_valid = vt[i].cv;
         bus.m_ready = vt[i].mr;
         bus.m_other_error = vt[i].er;
         bus.m_rdata = 32'hD000_0000 + i;
         #1;
         chk($sformatf("vec%0d m_valid", i), 32'(bus.m_valid), 32'(vt[i].mv));
         chk($sformatf("vec%0d m_addr", i), bus.m_addr, vt[i].addr);
         chk($sformatf("vec%0d ch_ready", i), 32'(bus.ch_ready), 32'(vt[i].cr));
         chk($sformatf("vec%0d ch_error", i), 32'(bus.ch_error), 32'(vt[i].ce));
         chk($sformatf("vec%0d ch_rdata", i), bus.ch_rdata, vt[i].cr != 0 ? 32'hD000_0000 + i : 32'd0);
         @(negedge clk);
      end
      bus.m_ready = 1'b0;
      bus.m_other_error = 1'b0;
      #1;
      // INCR4 on ch1 holds the grant against ch2
      set_ch(1, 32'h100, HB_INCR4, 1'b1, 32'h11);
      set_ch(2, 32'h2000, HB_SINGLE, 1'b1, 32'h22);
      bus.ch_valid = 4'b0110;
      for (int b = 0; b < 4; b++) begin
         beat($sformatf("incr4 b%0d", b), 32'h100 + 4 * b, 4'b0010, 1'b0);
         bus.ch_addr[1*AW +: AW] = 32'h104 + 4 * b;
      end
      bus.ch_valid[1] = 1'b0;
      beat("after lock", 32'h2000, 4'b0100, 1'b0);
      bus.ch_valid = 4'b0000;
      // WRAP8 read aborted by error on beat 3, waiting ch3 then served
      set_ch(0, 32'h40, HB_WRAP8, 1'b0, 32'h0);
      set_ch(3, 32'h3000, HB_SINGLE, 1'b1, 32'h33);
      bus.ch_valid = 4'b0001;
      for (int b = 0; b < 4; b++) begin
         beat($sformatf("wrap8 b%0d", b), 32'h40 + 4 * b, 4'b0001, b == 3);
         bus.ch_addr[0 +: AW] = 32'h44 + 4 * b;
         bus.ch_valid[3] = 1'b1;
      end
      bus.ch_valid[0] = 1'b0;
      beat("after abort", 32'h3000, 4'b1000, 1'b0);
      bus.ch_valid = 4'b0000;
      // master stalls for 10 cycles: request held stable, no completion
      set_ch(2, 32'h2000, HB_SINGLE, 1'b1, 32'h55AA_55AA);
      bus.ch_valid = 4'b0100;
      @(negedge clk);
      #1;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("stall%0d m_valid", k), 32'(bus.m_valid), 32'd1);
         chk($sformatf("stall%0d m_addr", k), bus.m_addr, 32'h2000);
         chk($sformatf("stall%0d m_wdata", k), bus.m_wdata, 32'h55AA_55AA);
         chk($sformatf("stall%0d ch_ready", k), 32'(bus.ch_ready), 32'd0);
         @(negedge clk);
         #1;
      end
      beat("stall done", 32'h2000, 4'b0100, 1'b0);
      bus.ch_valid = 4'b0000;
      // reset during beat 5 of an INCR16 burst
      set_ch(0, 32'h800, HB_INCR16, 1'b1, 32'h77);
      bus.ch_valid = 4'b0001;
      for (int b = 0; b < 5; b++) begin
         beat($sformatf("incr16 b%0d", b), 32'h800 + 4 * b, 4'b0001, 1'b0);
         bus.ch_addr[0 +: AW] = 32'h804 + 4 * b;
      end
      @(negedge clk);
      #1;
      chk("incr16 b5 m_valid", 32'(bus.m_valid), 32'd1);
      bus.m_ready = 1'b1;
      rstn = 1'b0;
      #1;
      chk("midburst rst m_valid", 32'(bus.m_valid), 32'd0);
      chk("midburst rst m_addr", bus.m_addr, 32'd0);
      chk("midburst rst ch_ready", 32'(bus.ch_ready), 32'd0);
      bus.m_ready = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      set_ch(0, 32'h10, HB_SINGLE, 1'b1, 32'h1);
      set_ch(1, 32'h1010, HB_SINGLE, 1'b1, 32'h2);
      bus.ch_valid = 4'b0011;
      beat("post rst ch0", 32'h10, 4'b0001, 1'b0);
      bus.ch_valid = 4'b0010;
      beat("post rst ch1", 32'h1010, 4'b0010, 1'b0);
      bus.ch_valid = 4'b0000;
`ifdef AHB_ARB_WSTRB_EN
      // strobes follow the granted write beat
      set_ch(2, 32'h2200, HB_SINGLE, 1'b1, 32'h9);
      bus.ch_strb = 16'h0F0F;
      bus.ch_strb[2*4 +: 4] = 4'b0110;
      bus.ch_valid = 4'b0100;
      @(negedge clk);
      #1;
      chk("strb m_strb", 32'(bus.m_strb), 32'b0110);
      beat("strb beat", 32'h2200, 4'b0100, 1'b0);
      bus.ch_valid = 4'b0000;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
